// File: rtl/scaler_hist_buf_if.sv
// Capture/pop bus between the scaler, firmware read port and the history buffer.
// master = scaler/firmware side, slave = history buffer.
interface scaler_hist_buf_if #(
    parameter int P_N_WIDTH    = 32,
    parameter int P_DEPTH_LOG2 = 6,
    parameter int P_SEQ_WIDTH  = 16
);
    logic                    enable;
    logic                    overwrite;
    logic                    clear;
    logic                    update_in;
    logic                    valid_in;
    logic [P_N_WIDTH-1:0]    scaler_in;
    logic                    rd_req;
    logic                    rd_valid;
    logic [P_N_WIDTH-1:0]    rd_data;
    logic [P_SEQ_WIDTH-1:0]  rd_seq;
    logic                    rd_sat;
    logic [47:0]             rd_tstamp;
    logic [P_DEPTH_LOG2:0]   n_entries;
    logic [15:0]             n_dropped;

    modport master (
        output enable, overwrite, clear, update_in, valid_in, scaler_in, rd_req,
        input  rd_valid, rd_data, rd_seq, rd_sat, rd_tstamp, n_entries, n_dropped
    );

    modport slave (
        input  enable, overwrite, clear, update_in, valid_in, scaler_in, rd_req,
        output rd_valid, rd_data, rd_seq, rd_sat, rd_tstamp, n_entries, n_dropped
    );
endinterface

// File: rtl/scaler_hist_buf.sv
// Scaler window history buffer: sequenced captures into a power-of-two FIFO/ring, popped by firmware.
// Optional capture timestamps: define SCALER_HIST_TSTAMP_EN.
module scaler_hist_buf #(
    parameter int P_N_WIDTH    = 32,
    parameter int P_DEPTH_LOG2 = 6,
    parameter int P_SEQ_WIDTH  = 16
) (
    input logic               clk,
    input logic               rst_n,
    scaler_hist_buf_if.slave  bus
);
    localparam int DEPTH = 1 << P_DEPTH_LOG2;
    localparam logic [P_DEPTH_LOG2:0] FULL_CNT = {1'b1, {P_DEPTH_LOG2{1'b0}}};
    localparam logic [P_DEPTH_LOG2-1:0] PTR_ONE = {{(P_DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [P_SEQ_WIDTH-1:0]  SEQ_ONE = {{(P_SEQ_WIDTH-1){1'b0}}, 1'b1};

    logic [P_N_WIDTH-1:0]    mem_data [DEPTH];
    logic [P_SEQ_WIDTH-1:0]  mem_seq  [DEPTH];
    logic                    mem_sat  [DEPTH];

    logic [P_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [P_DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic [P_SEQ_WIDTH-1:0]  seq_q, seq_d;
    logic [15:0]             dropped_q, dropped_d;
    logic                    rd_valid_q;
    logic [P_N_WIDTH-1:0]    rd_data_q;
    logic [P_SEQ_WIDTH-1:0]  rd_seq_q;
    logic                    rd_sat_q;

    logic capture, pop, full, wr_en, drop, rd_adv;

    always_comb begin
        capture   = bus.update_in & bus.valid_in & bus.enable & ~bus.clear;
        full      = (cnt_q == FULL_CNT);
        pop       = bus.rd_req & (cnt_q != '0) & ~bus.clear;
        // When full, a same-cycle pop frees the slot the new entry lands in.
        wr_en     = capture & (~full | pop | bus.overwrite);
        drop      = capture & full & ~pop;
        rd_adv    = pop | (drop & bus.overwrite);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        dropped_d = dropped_q;
        if (bus.clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            seq_d     = '0;
            dropped_d = '0;
        end else begin
            if (capture) seq_d = seq_q + SEQ_ONE;
            if (wr_en)   wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_adv)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({wr_en, rd_adv})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            if (drop && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr_q] <= bus.scaler_in;
            mem_seq[wr_ptr_q]  <= seq_q;
            mem_sat[wr_ptr_q]  <= (bus.scaler_in == {P_N_WIDTH{1'b1}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            seq_q      <= '0;
            dropped_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_seq_q   <= '0;
            rd_sat_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            dropped_q  <= dropped_d;
            rd_valid_q <= pop;
            if (pop) begin
                rd_data_q <= mem_data[rd_ptr_q];
                rd_seq_q  <= mem_seq[rd_ptr_q];
                rd_sat_q  <= mem_sat[rd_ptr_q];
            end
        end
    end

`ifdef SCALER_HIST_TSTAMP_EN
    logic [47:0] mem_ts [DEPTH];
    logic [47:0] tstamp_q, rd_tstamp_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_ts[wr_ptr_q] <= tstamp_q;
    end

    // Free-running: only rst_n restarts the timebase, clear does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tstamp_q    <= '0;
            rd_tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + 48'd1;
            if (pop) rd_tstamp_q <= mem_ts[rd_ptr_q];
        end
    end

    assign bus.rd_tstamp = rd_tstamp_q;
`else
    assign bus.rd_tstamp = 48'd0;
`endif

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_seq    = rd_seq_q;
    assign bus.rd_sat    = rd_sat_q;
    assign bus.n_entries = cnt_q;
    assign bus.n_dropped = dropped_q;
endmodule
